gen_scheduler: RTL and testbench

GEN_SCHEDULER -- requirements
Module: gen_scheduler

---
 rtl/vga_pkg.sv | 29 ++
 rtl/gen_rate_div.sv | 37 +++
 rtl/gen_scheduler.sv | 123 ++++++++++++
 tb/tb_gen_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 1280x1024@60Hz timing constants and the generation scheduler state encoding.
package vga_pkg;

    localparam int unsigned HActive    = 1280;
    localparam int unsigned VActive    = 1024;
    localparam int unsigned HCountMax  = 1688;
    localparam int unsigned VCountMax  = 1066;
    localparam int unsigned HSyncStart = 1328;
    localparam int unsigned HSyncEnd   = 1440;
    localparam int unsigned VSyncStart = 1025;
    localparam int unsigned VSyncEnd   = 1028;

    localparam int unsigned YW = $clog2(VCountMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StIssue,
        StActive,
        StSuspend
    } sched_state_e;

    function automatic logic in_span(input logic [YW-1:0] v,
                                     input logic [YW-1:0] lo,
                                     input logic [YW-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/gen_rate_div.sv
// Frame divider: emits one tick every (rate + 1) window opens while run is high.
module gen_rate_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] rate,
    input  logic       tick_in,
    output logic       tick_out
);

    logic [3:0] frm_cnt_q, frm_cnt_d;

    // >= so a rate lowered below the running count still fires at the next open
    always_comb begin
        frm_cnt_d = frm_cnt_q;
        tick_out  = 1'b0;
        if (!run) begin
            frm_cnt_d = '0;
        end else if (tick_in) begin
            if (frm_cnt_q >= rate) begin
                tick_out  = 1'b1;
                frm_cnt_d = '0;
            end else begin
                frm_cnt_d = frm_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt_q <= '0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
        end
    end

endmodule

// File: rtl/gen_scheduler.sv
// Schedules cell-update generations into the vertical blanking window and arbitrates
// the cell memory between the display and the update engine.
module gen_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_GUARD  = 1062,
    parameter int unsigned GEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [YW-1:0]    y,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       rate,
    input  logic             upd_req,
    input  logic             upd_done,
    output logic             upd_start,
    output logic             upd_gnt,
    output logic             mem_sel,
    output logic             busy,
    output logic             overrun,
    output logic [GEN_W-1:0] gen_count
);

    localparam logic [YW-1:0] YOpen  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] YClose = YW'(V_GUARD);

    sched_state_e     state_q, state_d;
    logic             win, win_q, win_open, tick;
    logic             pending_q, pending_d, consume;
    logic             gnt_q, gnt_d;
    logic             overrun_q, overrun_d, overrun_set;
    logic             done_acc;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;

    assign win      = in_span(y, YOpen, YClose);
    assign win_open = win && !win_q;

    // Tracks the line counter through reset so a reset inside the window sees no fresh open.
    always_ff @(posedge clk) begin
        win_q <= win;
    end

    gen_rate_div u_rate_div (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .rate    (rate),
        .tick_in (win_open),
        .tick_out(tick)
    );

    // The request is consumed on the edge into ISSUE; a trigger in that same cycle survives.
    assign consume   = (state_q == StArmed) && win_open;
    assign pending_d = step || tick || (pending_q && !consume);

    always_comb begin
        state_d     = state_q;
        overrun_set = 1'b0;
        done_acc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q) state_d = StArmed;
            end
            StArmed: begin
                if (win_open) state_d = StIssue;
            end
            StIssue: begin
                state_d = StActive;
            end
            StActive: begin
                if (upd_done) begin
                    state_d  = StIdle;
                    done_acc = 1'b1;
                end else if (!win) begin
                    state_d     = StSuspend;
                    overrun_set = 1'b1;
                end
            end
            StSuspend: begin
                if (upd_done) begin
                    state_d  = StIdle;
                    done_acc = 1'b1;
                end else if (win_open) begin
                    state_d = StActive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt_d       = (state_d == StActive) && win && upd_req;
    assign overrun_d   = overrun_q || overrun_set;
    assign gen_count_d = gen_count_q + GEN_W'(done_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            gnt_q       <= 1'b0;
            overrun_q   <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            gnt_q       <= gnt_d;
            overrun_q   <= overrun_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign upd_start = (state_q == StIssue);
    assign busy      = (state_q == StIssue) || (state_q == StActive) || (state_q == StSuspend);
    assign upd_gnt   = gnt_q;
    assign mem_sel   = gnt_q;
    assign overrun   = overrun_q;
    assign gen_count = gen_count_q;

    a_gnt_only_active: assert property (@(posedge clk) disable iff (rst)
        gnt_q |-> (state_q == StActive));

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler: compressed frame timing, scenario table and corner sequences.
module tb_gen_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] y;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  rate = 4'd0;
    logic        upd_req = 1'b0;
    logic        upd_done = 1'b0;
    logic        upd_start, upd_gnt, mem_sel, busy, overrun;
    logic [15:0] gen_count;

    always #5 clk = ~clk;

    gen_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .run      (run),
        .step     (step),
        .rate     (rate),
        .upd_req  (upd_req),
        .upd_done (upd_done),
        .upd_start(upd_start),
        .upd_gnt  (upd_gnt),
        .mem_sel  (mem_sel),
        .busy     (busy),
        .overrun  (overrun),
        .gen_count(gen_count)
    );

    int checks = 0;
    int errors = 0;
    int dwell = 8;
    int frame_no = 0;
    int eng_len = 100;
    int eng_cnt = 0;
    int n_starts = 0;
    int first_rel = -1;
    int last_rel = -1;
    int base_frame = 0;
    int v_gnt = 0, v_sel = 0, v_pos = 0, v_busy = 0;
    int lc = 0;
    logic [10:0] prev_y = 11'd0;

    typedef struct {
        bit         run;
        logic [3:0] rate;
        int         step_line;
        int         dwell;
        int         eng_len;
        int         frames;
        int         exp_starts;
        int         exp_gens;
        int         exp_first;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line counter: visible lines last one cycle, blanking lines 'dwell' cycles.
    initial begin
        int left;
        left = 0;
        y = 11'd0;
        forever begin
            @(negedge clk);
            if (left > 0) begin
                left--;
            end else begin
                y = (y == 11'd1066) ? 11'd0 : y + 11'd1;
                if (y == 11'd0) frame_no++;
                left = (y >= 11'd1024) ? dwell - 1 : 0;
            end
        end
    end

    // Update engine: requests the memory from upd_start and finishes eng_len cycles later.
    always @(negedge clk) begin
        if (rst) begin
            eng_cnt  = 0;
            upd_req  = 1'b0;
            upd_done = 1'b0;
        end else begin
            upd_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    upd_done = 1'b1;
                    upd_req  = 1'b0;
                end
            end
            if (upd_start) begin
                eng_cnt = eng_len;
                upd_req = 1'b1;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (y != prev_y) lc = 1;
        else lc++;
        prev_y = y;
        if (!rst) begin
            if (upd_gnt && !(y >= 11'd1024 && y < 11'd1062)) v_gnt++;
            if (mem_sel !== upd_gnt) v_sel++;
            if (upd_start) begin
                if (!busy) v_busy++;
                if (y != 11'd1024 || lc != 1) v_pos++;
                if (n_starts == 0) first_rel = frame_no - base_frame;
                last_rel = frame_no - base_frame;
                n_starts++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_line(input int line);
        int b;
        b = 0;
        while (int'(y) != line && b < 5000) begin
            cyc(1);
            b++;
        end
        if (int'(y) != line) check("wait_line timeout", int'(y), line);
    endtask

    task automatic wait_frames(input int target);
        int b;
        b = 0;
        while (frame_no < target && b < 30000) begin
            cyc(1);
            b++;
        end
        if (frame_no < target) check("wait_frames timeout", frame_no, target);
    endtask

    task automatic pulse_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic start_scenario(input bit run_v, input logic [3:0] rate_v,
                                  input int dwell_v, input int eng_v);
        wait_line(0);
        dwell   = dwell_v;
        eng_len = eng_v;
        @(negedge clk);
        rst  = 1'b1;
        run  = run_v;
        rate = rate_v;
        step = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        base_frame = frame_no;
        n_starts   = 0;
        first_rel  = -1;
        last_rel   = -1;
    endtask

    initial begin
        int b;
        vecs[0] = '{1'b1, 4'd0, -1,   28, 1000, 4, 3, 3, 1};
        vecs[1] = '{1'b1, 4'd2, -1,   8,  100,  7, 2, 2, 3};
        vecs[2] = '{1'b1, 4'd1, -1,   8,  100,  5, 2, 2, 2};
        vecs[3] = '{1'b0, 4'd0, 10,   8,  100,  1, 1, 1, 0};
        vecs[4] = '{1'b0, 4'd0, 1030, 8,  100,  1, 0, 0, -1};
        vecs[5] = '{1'b0, 4'd0, 1030, 8,  100,  2, 1, 1, 1};
        vecs[6] = '{1'b1, 4'd0, 10,   8,  100,  2, 2, 2, 0};

        cyc(3);
        check("reset upd_start", int'(upd_start), 0);
        check("reset upd_gnt", int'(upd_gnt), 0);
        check("reset mem_sel", int'(mem_sel), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset gen_count", int'(gen_count), 0);

        for (int i = 0; i < 7; i++) begin
            start_scenario(vecs[i].run, vecs[i].rate, vecs[i].dwell, vecs[i].eng_len);
            if (vecs[i].step_line >= 0) begin
                wait_line(vecs[i].step_line);
                pulse_step();
            end
            wait_frames(base_frame + vecs[i].frames);
            check($sformatf("v%0d starts", i), n_starts, vecs[i].exp_starts);
            check($sformatf("v%0d gen_count", i), int'(gen_count), vecs[i].exp_gens);
            check($sformatf("v%0d first start frame", i), first_rel, vecs[i].exp_first);
            check($sformatf("v%0d overrun", i), int'(overrun), 0);
        end

        // Rate 3 lowered to 1 after the first divider tick.
        start_scenario(1'b1, 4'd3, 8, 100);
        wait_frames(base_frame + 4);
        @(negedge clk) rate = 4'd1;
        wait_frames(base_frame + 7);
        check("rate change starts", n_starts, 2);
        check("rate change first", first_rel, 4);
        check("rate change second", last_rel, 6);

        // Three steps while busy collapse into one further generation.
        start_scenario(1'b0, 4'd0, 8, 150);
        wait_line(10);
        pulse_step();
        wait_line(1024);
        cyc(3);
        check("steps busy", int'(busy), 1);
        repeat (3) begin
            pulse_step();
            cyc(5);
        end
        wait_frames(base_frame + 3);
        check("steps starts", n_starts, 2);
        check("steps second frame", last_rel, 1);
        check("steps gen_count", int'(gen_count), 2);

        // Generation spanning the window close.
        start_scenario(1'b0, 4'd0, 8, 1450);
        wait_line(10);
        pulse_step();
        wait_line(1040);
        check("ovr gnt in window", int'(upd_gnt), 1);
        check("ovr overrun before", int'(overrun), 0);
        wait_line(1062);
        cyc(2);
        check("ovr gnt after close", int'(upd_gnt), 0);
        check("ovr overrun set", int'(overrun), 1);
        check("ovr busy held", int'(busy), 1);
        wait_line(500);
        check("ovr gnt visible", int'(upd_gnt), 0);
        wait_line(1024);
        cyc(3);
        check("ovr gnt resumed", int'(upd_gnt), 1);
        b = 0;
        while (busy && b < 2000) begin
            cyc(1);
            b++;
        end
        cyc(1);
        check("ovr done busy", int'(busy), 0);
        check("ovr gen_count", int'(gen_count), 1);
        check("ovr overrun sticky", int'(overrun), 1);

        // Reset while the engine holds the memory.
        start_scenario(1'b1, 4'd0, 8, 100);
        wait_frames(base_frame + 2);
        check("rst pre gen_count", int'(gen_count), 1);
        b = 0;
        while (!upd_gnt && b < 3000) begin
            cyc(1);
            b++;
        end
        check("rst pre gnt", int'(upd_gnt), 1);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        cyc(1);
        check("rst gnt", int'(upd_gnt), 0);
        check("rst mem_sel", int'(mem_sel), 0);
        check("rst gen_count", int'(gen_count), 0);
        check("rst busy", int'(busy), 0);
        @(negedge clk) rst = 1'b0;
        n_starts   = 0;
        base_frame = frame_no;
        wait_frames(base_frame + 2);
        check("rst no restart", n_starts, 0);

        check("gnt outside window", v_gnt, 0);
        check("mem_sel vs gnt", v_sel, 0);
        check("start position", v_pos, 0);
        check("start without busy", v_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
